dds_lfm: RTL and testbench



---
 rtl/dds_pkg.sv | 33 +++
 rtl/dds_sin_lut.sv | 25 ++
 rtl/dds_lfm.sv | 56 +++++
 tb/tb_dds_lfm.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants, typedefs and the elaboration-time sine table generator
// for the chirp DDS.
package dds_pkg;
  localparam int DEF_N_PHASE   = 32;
  localparam int DEF_LUT_BITS  = 10;
  localparam int DEF_OUT_WIDTH = 16;

  typedef logic        [DEF_N_PHASE-1:0]   phase_t;
  typedef logic signed [DEF_OUT_WIDTH-1:0] sample_t;

  // round((2^(out_width-1)-1) * sin(2*pi*index/2^lut_bits)); the index is folded
  // into the first quadrant so the Taylor series only ever sees [0, pi/2].
  function automatic int sin_value(int index, int lut_bits, int out_width);
    real pi_v, x, x2, term, sum, amp;
    int  quarter, q, r, mag;
    pi_v    = 3.14159265358979323846;
    quarter = 1 << (lut_bits - 2);
    q       = (index >> (lut_bits - 2)) & 3;
    r       = index & (quarter - 1);
    if (q[0]) r = quarter - r;
    x    = pi_v * real'(r) / real'(2 * quarter);
    x2   = x * x;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((1 << (out_width - 1)) - 1);
    mag = $rtoi(amp * sum + 0.5);
    return q[1] ? -mag : mag;
  endfunction
endpackage

// File: rtl/dds_sin_lut.sv
// Full-period sine ROM built at elaboration, with a registered signed output.
module dds_sin_lut
  import dds_pkg::*;
#(
  parameter int LUT_BITS  = DEF_LUT_BITS,
  parameter int LUT_SIZE  = 1 << LUT_BITS,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LUT_BITS-1:0]         addr,
  output logic signed [OUT_WIDTH-1:0] dout
);
  logic signed [OUT_WIDTH-1:0] rom [LUT_SIZE];

  for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
    localparam int V = sin_value(i, LUT_BITS, OUT_WIDTH);
    assign rom[i] = OUT_WIDTH'(V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= rom[addr];
  end
endmodule

// File: rtl/dds_lfm.sv
// Free-running linear-FM DDS: FTW ramps by DELTA_FTW each clock, the phase
// accumulator integrates it, and the phase MSBs address a sine ROM.
module dds_lfm
  import dds_pkg::*;
#(
  parameter int                 N_PHASE   = DEF_N_PHASE,
  parameter int                 LUT_BITS  = DEF_LUT_BITS,
  parameter int                 LUT_SIZE  = 1 << LUT_BITS,
  parameter int                 OUT_WIDTH = DEF_OUT_WIDTH,
  parameter logic [N_PHASE-1:0] INIT_FTW  = 'h2A,
  parameter logic [N_PHASE-1:0] DELTA_FTW = '0,
  parameter int                 SWEEP_LEN = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic signed [OUT_WIDTH-1:0] dout
);
  localparam int CNT_W = (SWEEP_LEN > 1) ? $clog2(SWEEP_LEN) : 1;

  logic [N_PHASE-1:0] phase_acc;
  logic [N_PHASE-1:0] ftw;
  logic [CNT_W-1:0]   sweep_cnt;
  logic               sweep_end;

  // SWEEP_LEN of 0 disables the reload entirely and the counter idles at 0.
  assign sweep_end = (SWEEP_LEN > 0) && (sweep_cnt == CNT_W'(SWEEP_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      ftw       <= INIT_FTW;
      sweep_cnt <= '0;
    end else begin
      // Phase is never cleared on a sweep restart so the output stays continuous.
      phase_acc <= phase_acc + ftw;
      if (sweep_end) begin
        ftw       <= INIT_FTW;
        sweep_cnt <= '0;
      end else begin
        ftw <= ftw + DELTA_FTW;
        if (SWEEP_LEN > 0) sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
    end
  end

  dds_sin_lut #(
    .LUT_BITS  (LUT_BITS),
    .LUT_SIZE  (LUT_SIZE),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (phase_acc[N_PHASE-1 -: LUT_BITS]),
    .dout  (dout)
  );
endmodule

// File: tb/tb_dds_lfm.sv
// Bench for dds_lfm: five parameterisations share clock and reset; every edge is
// compared against a closed-form phase/FTW model and a $sin-based sine table.
module tb_dds_lfm;
  localparam int NI = 5;
  localparam logic [31:0] P_INIT  [NI] = '{32'h40000000, 32'h00000000, 32'hFFC00000,
                                           32'h0000002A, 32'h01000000};
  localparam logic [31:0] P_DELTA [NI] = '{32'h00000000, 32'h00400000, 32'h00400000,
                                           32'h00000000, 32'h01000000};
  localparam int          P_LEN   [NI] = '{0, 0, 0, 0, 4};

  logic clk;
  logic rst_n;
  logic signed [15:0] dout_a [NI];
  logic [31:0]        ph_a   [NI];
  logic [31:0]        ftw_a  [NI];
  string names [NI] = '{"tone", "chirp", "wrap", "dflt", "sweep"};

  int checks;
  int failures;

  dds_lfm #(.INIT_FTW(P_INIT[0]), .DELTA_FTW(P_DELTA[0]), .SWEEP_LEN(P_LEN[0]))
    u_tone  (.clk(clk), .rst_n(rst_n), .dout(dout_a[0]));
  dds_lfm #(.INIT_FTW(P_INIT[1]), .DELTA_FTW(P_DELTA[1]), .SWEEP_LEN(P_LEN[1]))
    u_chirp (.clk(clk), .rst_n(rst_n), .dout(dout_a[1]));
  dds_lfm #(.INIT_FTW(P_INIT[2]), .DELTA_FTW(P_DELTA[2]), .SWEEP_LEN(P_LEN[2]))
    u_wrap  (.clk(clk), .rst_n(rst_n), .dout(dout_a[2]));
  dds_lfm u_dflt (.clk(clk), .rst_n(rst_n), .dout(dout_a[3]));
  dds_lfm #(.INIT_FTW(P_INIT[4]), .DELTA_FTW(P_DELTA[4]), .SWEEP_LEN(P_LEN[4]))
    u_sweep (.clk(clk), .rst_n(rst_n), .dout(dout_a[4]));

  assign ph_a[0]  = u_tone.phase_acc;   assign ftw_a[0] = u_tone.ftw;
  assign ph_a[1]  = u_chirp.phase_acc;  assign ftw_a[1] = u_chirp.ftw;
  assign ph_a[2]  = u_wrap.phase_acc;   assign ftw_a[2] = u_wrap.ftw;
  assign ph_a[3]  = u_dflt.phase_acc;   assign ftw_a[3] = u_dflt.ftw;
  assign ph_a[4]  = u_sweep.phase_acc;  assign ftw_a[4] = u_sweep.ftw;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lut_ref(int idx);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Phase after j edges = sum of the FTWs used on those edges, in closed form.
  function automatic logic [31:0] mphase(int i, int j);
    longint unsigned jj, l, c, r, acc;
    jj = longint'(j);
    l  = longint'(P_LEN[i]);
    if (l == 0) begin
      acc = jj * P_INIT[i] + ((jj * (jj - 1)) / 2) * P_DELTA[i];
    end else begin
      c   = jj / l;
      r   = jj % l;
      acc = jj * P_INIT[i] + P_DELTA[i] * (c * ((l * (l - 1)) / 2) + (r * (r - 1)) / 2);
    end
    return acc[31:0];
  endfunction

  function automatic logic [31:0] exp_ftw(int i, int k);
    longint unsigned steps;
    steps = (P_LEN[i] == 0) ? longint'(k) : longint'(k % P_LEN[i]);
    return 32'(P_INIT[i] + steps * P_DELTA[i]);
  endfunction

  function automatic int exp_dout(int i, int k);
    logic [31:0] p;
    if (k == 0) return 0;
    p = mphase(i, k - 1);
    return lut_ref(int'(p >> 22));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_%s_dout", tag, names[i]), dout_a[i], 64'(0));
      chk($sformatf("%s_%s_phase", tag, names[i]), ph_a[i], 64'(0));
      chk($sformatf("%s_%s_ftw", tag, names[i]), ftw_a[i], 64'(P_INIT[i]));
    end
  endtask

  task automatic run_edges(string seg, int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("%s_%s_dout_e%0d", seg, names[i], k), dout_a[i], 64'(exp_dout(i, k)));
        chk($sformatf("%s_%s_ftw_e%0d", seg, names[i], k), ftw_a[i], 64'(exp_ftw(i, k)));
        chk($sformatf("%s_%s_phase_e%0d", seg, names[i], k), ph_a[i], 64'(mphase(i, k)));
      end
      if (k == 1) chk({seg, "_wrap_ftw_zero"}, ftw_a[2], 64'(0));
      if (k == 2) chk({seg, "_tone_peak"}, dout_a[0], 64'(32767));
      if (k == 3) chk({seg, "_chirp_lut1"}, dout_a[1], 64'(201));
      if (k == 4) chk({seg, "_tone_trough"}, dout_a[0], -64'sd32767);
      if (k == 4) chk({seg, "_sweep_reload"}, ftw_a[4], 64'(32'h01000000));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    // Reset held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");

    @(negedge clk);
    rst_n = 1'b1;
    run_edges("run0", $urandom_range(40, 80));

    // Asynchronous reset between edges, held a few cycles, then a clean restart.
    for (int round = 1; round <= 2; round++) begin
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_reset($sformatf("async%0d", round));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      check_reset($sformatf("hold%0d", round));
      @(negedge clk);
      rst_n = 1'b1;
      run_edges($sformatf("run%0d", round), $urandom_range(30, 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
